// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types used by the core and its bus responders.
package dbus_responder_pkg;

  localparam int unsigned DBUS_AW = 64;
  localparam int unsigned DBUS_DW = 64;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef struct packed {
    logic                 valid;
    logic [DBUS_AW-1:0]   addr;
    msize_t               size;
    logic [7:0]           strobe;
    logic [DBUS_DW-1:0]   data;
  } dbus_req_t;

  typedef struct packed {
    logic                 addr_ok;
    logic                 data_ok;
    logic [DBUS_DW-1:0]   data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_responder_sram.sv
// Single-port 64-bit word store with per-byte write enables and a
// registered read port. Contents are never reset.
module sram_bytewrite #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [63:0] mem [WORDS];

  // byte-masked write and registered read on the same port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dbus_responder.sv
// Fixed-latency data-bus responder backed by a byte-writable word store.
//
// state | meaning
// IDLE  | waiting for dreq.valid; request fields latched on acceptance
// BUSY  | counting down the access latency; read issued in its last cycle
// RESP  | addr_ok/data_ok pulse for one cycle; write commits on this edge
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned AW    = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             load;

  logic [AW-1:0]    lat_idx;
  logic             lat_in_range;
  logic [7:0]       lat_strobe;
  logic [63:0]      lat_data;

  logic [63:0]      req_off;
  logic             req_in_range;
  logic [AW-1:0]    req_idx;

  logic             mem_re, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [63:0]      mem_rdata;

  // size and the byte offset within the word play no part in addressing
  logic unused_req;
  assign unused_req = ^{dreq.size, req_off[2:0]};

  // range check works on the offset so BASE_ADDR + window never overflows
  assign req_off      = dreq.addr - BASE_ADDR;
  assign req_in_range = (dreq.addr >= BASE_ADDR) && (req_off[63:3] < 61'(MEM_WORDS));
  assign req_idx      = req_off[AW+2:3];

  // state, countdown and latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_idx      <= '0;
      lat_in_range <= 1'b0;
      lat_strobe   <= '0;
      lat_data     <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (load) begin
        lat_idx      <= req_idx;
        lat_in_range <= req_in_range;
        lat_strobe   <= dreq.strobe;
        lat_data     <= dreq.data;
      end
    end
  end

  // next-state: a withdrawn request in BUSY aborts without a response
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (dreq.valid) begin
          load   = 1'b1;
          cnt_nx = CNT_W'(LATENCY - 1);
          if (LATENCY == 1) state_nx = RESP;
          else              state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!dreq.valid) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 1'b1;
          if (cnt_nx == '0) state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // read lands in the register exactly as RESP begins; write is held back by reset
  always_comb begin
    mem_re   = (state_nx == RESP) && !reset;
    mem_we   = (state == RESP) && lat_in_range && (lat_strobe != 8'h00) && !reset;
    mem_addr = (state == IDLE) ? req_idx : lat_idx;
  end

  sram_bytewrite #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .re    (mem_re),
    .we    (mem_we),
    .be    (lat_strobe),
    .addr  (mem_addr),
    .wdata (lat_data),
    .rdata (mem_rdata)
  );

  // response is only non-zero during RESP; out-of-range returns zero data
  always_comb begin
    dresp = '0;
    if (state == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = lat_in_range ? mem_rdata : 64'h0;
    end
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Scoreboard bench: three responders (LATENCY 2, 1, 4) against a word-array model.
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic       clk;
  logic       rst_a   [3];
  dbus_req_t  dreq_a  [3];
  dbus_resp_t dresp_a [3];

  int words_m [3] = '{1024, 16, 64};
  int lat_m   [3] = '{2, 1, 4};

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          dut;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t exp_q [$];

  logic [63:0] mem_m [3][1024];

  dbus_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst_a[0]), .dreq(dreq_a[0]), .dresp(dresp_a[0]));
  dbus_responder #(.MEM_WORDS(16), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst_a[1]), .dreq(dreq_a[1]), .dresp(dresp_a[1]));
  dbus_responder #(.MEM_WORDS(64), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(rst_a[2]), .dreq(dreq_a[2]), .dresp(dresp_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference: word addressed by (addr - BASE) / 8 when inside the window, else zero
  function automatic logic [63:0] model_peek(int k, logic [63:0] addr);
    longint unsigned a;
    a = addr;
    if (a < BASE || a >= BASE + 64'(8 * words_m[k])) return 64'h0;
    return mem_m[k][int'((a - BASE) / 8)];
  endfunction

  function automatic void model_write(int k, logic [63:0] addr, logic [7:0] strb, logic [63:0] data);
    longint unsigned a;
    int idx;
    a = addr;
    if (a < BASE || a >= BASE + 64'(8 * words_m[k])) return;
    idx = int'((a - BASE) / 8);
    for (int i = 0; i < 8; i++)
      if (strb[i]) mem_m[k][idx][8*i +: 8] = data[8*i +: 8];
  endfunction

  task automatic drive(input int k, input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] data);
    dreq_a[k].valid  = 1'b1;
    dreq_a[k].addr   = addr;
    dreq_a[k].size   = msize_t'($urandom_range(0, 3));
    dreq_a[k].strobe = strb;
    dreq_a[k].data   = data;
  endtask

  // issue one request now (just after a rising edge) and hold it until data_ok
  task automatic do_req(input int k, input logic [63:0] addr, input logic [7:0] strb,
                        input logic [63:0] data, input bit keep);
    exp_t e;
    bit   seen;
    drive(k, addr, strb, data);
    e.dut  = k;
    e.data = model_peek(k, addr);
    e.due  = cyc + lat_m[k];
    model_write(k, addr, strb, data);
    exp_q.push_back(e);
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (dresp_a[k].data_ok === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL timeout dut%0d addr=%h: no data_ok within 40 cycles", k, addr);
    end
    @(posedge clk); #1;
    if (!keep) dreq_a[k].valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_addr(int k, int known);
    int r;
    logic [63:0] low;
    r   = $urandom_range(0, 9);
    low = 64'($urandom_range(0, 7));
    if (r == 0) return BASE - 64'(8 * $urandom_range(1, 4)) + low;
    if (r == 1) return BASE + 64'(8 * words_m[k]) + 64'(8 * $urandom_range(0, 3)) + low;
    return BASE + 64'(8 * $urandom_range(0, known - 1)) + low;
  endfunction

  function automatic logic [7:0] rand_strb();
    if ($urandom_range(0, 2) == 0) return 8'h00;
    return 8'($urandom_range(1, 255));
  endfunction

  function automatic logic [63:0] rand_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic random_mix(input int k, input int known, input int n);
    for (int i = 0; i < n; i++)
      do_req(k, rand_addr(k, known), rand_strb(), rand_data(), (i != n - 1));
  endtask

  // monitor: every data_ok consumes one expectation; otherwise the response must be all zero
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (dresp_a[k].data_ok === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp dut%0d cyc=%0d data=%h", k, cyc, dresp_a[k].data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.dut != k || e.due != cyc || dresp_a[k].data !== e.data || dresp_a[k].addr_ok !== 1'b1) begin
            fails++;
            $display("FAIL resp dut%0d: got cyc=%0d data=%h addr_ok=%b, want dut%0d cyc=%0d data=%h addr_ok=1",
                     k, cyc, dresp_a[k].data, dresp_a[k].addr_ok, e.dut, e.due, e.data);
          end
        end
      end else begin
        tests++;
        if (dresp_a[k] !== '0) begin
          fails++;
          $display("FAIL idle_resp dut%0d cyc=%0d: got %h, want 0", k, cyc, dresp_a[k]);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      dreq_a[k] = '0;
      rst_a[k]  = 1'b1;
    end
    idle_cycles(3);

    // reset release and first request in the same cycle
    for (int k = 0; k < 3; k++) rst_a[k] = 1'b0;
    do_req(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
    do_req(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0);
    do_req(0, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 1'b0);
    do_req(0, 64'h8000_0013, 8'h00, 64'h0, 1'b0);
    for (int w = 0; w < 8; w++)
      if (w != 2) do_req(0, BASE + 64'(8 * w), 8'hFF, rand_data(), 1'b0);
    do_req(0, BASE + 64'h1FF8, 8'hFF, rand_data(), 1'b0);
    idle_cycles(2);
    // back-to-back reads with valid held throughout
    do_req(0, 64'h8000_0000, 8'h00, 64'h0, 1'b1);
    do_req(0, 64'h8000_0008, 8'h00, 64'h0, 1'b0);
    // window edges
    do_req(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 1'b0);
    do_req(0, 64'h8000_2000, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
    do_req(0, 64'h8000_0000, 8'h00, 64'h0, 1'b0);
    do_req(0, 64'h8000_1FF8, 8'h00, 64'h0, 1'b0);
    random_mix(0, 8, 40);
    idle_cycles(2);

    // LATENCY=1: fill the store, then a long back-to-back random mix
    for (int w = 0; w < 16; w++) do_req(1, BASE + 64'(8 * w), 8'hFF, rand_data(), 1'b1);
    do_req(1, BASE + 64'h8, 8'h00, 64'h0, 1'b0);
    random_mix(1, 16, 200);
    idle_cycles(2);

    // LATENCY=4: aborts by reset in BUSY, by dropped valid, and by reset in RESP
    for (int w = 0; w < 64; w++) do_req(2, BASE + 64'(8 * w), 8'hFF, rand_data(), 1'b1);
    do_req(2, 64'h8000_0018, 8'h00, 64'h0, 1'b0);

    drive(2, 64'h8000_0018, 8'hFF, 64'h0123_4567_89AB_CDEF);
    idle_cycles(2);
    rst_a[2] = 1'b1;
    dreq_a[2].valid = 1'b0;
    idle_cycles(1);
    rst_a[2] = 1'b0;
    idle_cycles(8);
    do_req(2, 64'h8000_0018, 8'h00, 64'h0, 1'b0);

    drive(2, 64'h8000_0020, 8'hFF, 64'h5555_6666_7777_8888);
    idle_cycles(1);
    dreq_a[2].valid = 1'b0;
    idle_cycles(6);
    do_req(2, 64'h8000_0020, 8'h00, 64'h0, 1'b0);

    begin
      exp_t e;
      drive(2, 64'h8000_0028, 8'hF0, 64'h9999_AAAA_BBBB_CCCC);
      e.dut  = 2;
      e.data = model_peek(2, 64'h8000_0028);
      e.due  = cyc + 4;
      exp_q.push_back(e);
      idle_cycles(4);
      rst_a[2] = 1'b1;
      dreq_a[2].valid = 1'b0;
      idle_cycles(1);
      rst_a[2] = 1'b0;
      idle_cycles(4);
    end
    do_req(2, 64'h8000_0028, 8'h00, 64'h0, 1'b0);
    random_mix(2, 64, 20);

    idle_cycles(6);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover_expect: got %0d pending responses, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
